// File: rtl/params_pkg.sv
// -----------------------------------------------------------------------------
// params_pkg
// Shared definitions for the multi-cycle core control path:
//   - datapath / instruction widths and the CONST4 increment
//   - RV32I major opcode values driven to the ALU
//   - controller state, ALU operand-select and write-back-select encodings
//   - is_exec_opcode(): opcodes that take the generic EXEC path after DECODE
// -----------------------------------------------------------------------------
package params_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] CONST4 = 32'd4;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM_RD = 4'd4,
        ST_MEM_WR = 4'd5,
        ST_WB     = 4'd6,
        ST_WB_MEM = 4'd7,
        ST_BR     = 4'd8,
        ST_JMP    = 4'd9,
        ST_TRAP   = 4'd10
    } ctrl_state_e;

    typedef enum logic [1:0] {
        A_PC     = 2'b00,
        A_OLD_PC = 2'b01,
        A_RS1    = 2'b10,
        A_ZERO   = 2'b11
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        B_RS2    = 2'b00,
        B_IMM    = 2'b01,
        B_CONST4 = 2'b10
    } alu_b_sel_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'b00,
        WB_MEMDAT = 2'b01,
        WB_PC     = 2'b10
    } wb_sel_e;

    // Opcodes that go DECODE -> EXEC
    function automatic logic is_exec_opcode(input logic [6:0] op);
        logic r;
        case (op)
            OPC_R, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC: r = 1'b1;
            default:                                                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Purely combinational branch resolution from the ALU flags.
// Ports:
//   funct3_i [2:0]  branch funct3 (BEQ/BNE/BLT/BGE supported)
//   zero_i          ALU is_zero (rs1 == rs2)
//   less_i          ALU is_less (signed rs1 < rs2)
//   taken_o         branch condition holds
//   valid_o         funct3 names a supported branch; taken_o is 0 otherwise
// -----------------------------------------------------------------------------
module branch_cond (
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       less_i,
    output logic       taken_o,
    output logic       valid_o
);

    // Decode funct3 into a condition on the flags
    always_comb begin
        taken_o = 1'b0;
        valid_o = 1'b1;
        case (funct3_i)
            3'b000:  taken_o = zero_i;
            3'b001:  taken_o = ~zero_i;
            3'b100:  taken_o = less_i;
            3'b101:  taken_o = ~less_i;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control FSM: FETCH / DECODE / EXEC / MEM / WB sequencing, ALU
// operation and operand selection, datapath enables, branch resolution.
// Outputs are decoded combinationally from the registered state, instr_i and
// mem_valid_i; in RESET every output is 0.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   instr_i [31:0]        instruction register contents
//   mem_valid_i           memory completed current request
//   alu_zero_i/alu_less_i ALU flags for branch resolution
//   mem_req_o, mem_we_o, mem_addr_sel_o (0 PC, 1 ALUOut)
//   ir_we_o, pc_we_o, pc_sel_o (0 ALU result, 1 ALUOut), rf_we_o
//   wb_sel_o [1:0]        00 ALUOut, 01 mem data, 10 PC
//   alu_opcode_o/alu_funct3_o/alu_funct7_o  ALU operation
//   alu_a_sel_o [1:0]     00 PC, 01 OLD_PC, 10 RS1, 11 ZERO
//   alu_b_sel_o [1:0]     00 RS2, 01 IMM, 10 CONST4
//   illegal_o             sticky illegal-instruction flag (TRAP until reset)
//
// Optional feature (macro CTRL_PERF_CNT_EN): adds instret_o [31:0], a
// retired-instruction counter bumped on every return to FETCH from
// WB, WB_MEM, MEM_WR, BR or JMP.
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import params_pkg::*;
#(
    parameter int INSTR_W = params_pkg::INSTR_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               mem_valid_i,
    input  logic               alu_zero_i,
    input  logic               alu_less_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               mem_addr_sel_o,
    output logic               ir_we_o,
    output logic               pc_we_o,
    output logic               pc_sel_o,
    output logic               rf_we_o,
    output logic [1:0]         wb_sel_o,
    output logic [6:0]         alu_opcode_o,
    output logic [2:0]         alu_funct3_o,
    output logic [6:0]         alu_funct7_o,
    output logic [1:0]         alu_a_sel_o,
    output logic [1:0]         alu_b_sel_o,
    output logic               illegal_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        instret_o
`endif
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       br_taken_s;
    logic       br_valid_s;
    logic       unused_instr_s;

    assign opcode_s = instr_i[6:0];
    assign funct3_s = instr_i[14:12];
    assign funct7_s = instr_i[31:25];

    // Register fields are consumed by the datapath, not by the controller
    assign unused_instr_s = ^{instr_i[24:15], instr_i[11:7]};

    branch_cond u_branch_cond (
        .funct3_i (funct3_s),
        .zero_i   (alu_zero_i),
        .less_i   (alu_less_i),
        .taken_o  (br_taken_s),
        .valid_o  (br_valid_s)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d        = state_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_sel_o       = 1'b0;
        rf_we_o        = 1'b0;
        wb_sel_o       = WB_ALUOUT;
        alu_opcode_o   = 7'd0;
        alu_funct3_o   = 3'd0;
        alu_funct7_o   = 7'd0;
        alu_a_sel_o    = A_PC;
        alu_b_sel_o    = B_RS2;
        illegal_o      = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_valid_i) begin
                    // Latch IR and advance PC to PC+4 in the same cycle
                    ir_we_o      = 1'b1;
                    pc_we_o      = 1'b1;
                    alu_opcode_o = OPC_AUIPC;
                    alu_a_sel_o  = A_PC;
                    alu_b_sel_o  = B_CONST4;
                    state_d      = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_DECODE: begin
                // Speculatively compute the branch/JAL target into ALUOut
                alu_opcode_o = OPC_AUIPC;
                alu_a_sel_o  = A_OLD_PC;
                alu_b_sel_o  = B_IMM;
                if (is_exec_opcode(opcode_s)) begin
                    state_d = ST_EXEC;
                end else if (opcode_s == OPC_BRANCH) begin
                    state_d = ST_BR;
                end else if (opcode_s == OPC_JAL) begin
                    state_d = ST_JMP;
                end else begin
                    state_d = ST_TRAP;
                end
            end

            ST_EXEC: begin
                alu_opcode_o = opcode_s;
                alu_funct3_o = funct3_s;
                alu_funct7_o = funct7_s;
                if (opcode_s == OPC_LUI) begin
                    alu_a_sel_o = A_ZERO;
                end else if (opcode_s == OPC_AUIPC) begin
                    alu_a_sel_o = A_OLD_PC;
                end else begin
                    alu_a_sel_o = A_RS1;
                end
                if (opcode_s == OPC_R) begin
                    alu_b_sel_o = B_RS2;
                end else begin
                    alu_b_sel_o = B_IMM;
                end
                if (opcode_s == OPC_LOAD) begin
                    state_d = ST_MEM_RD;
                end else if (opcode_s == OPC_STORE) begin
                    state_d = ST_MEM_WR;
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_MEM_RD: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                if (mem_valid_i) begin
                    state_d = ST_WB_MEM;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end

            ST_MEM_WR: begin
                mem_req_o      = 1'b1;
                mem_we_o       = 1'b1;
                mem_addr_sel_o = 1'b1;
                if (mem_valid_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end

            ST_WB: begin
                rf_we_o  = 1'b1;
                wb_sel_o = WB_ALUOUT;
                state_d  = ST_FETCH;
            end

            ST_WB_MEM: begin
                rf_we_o  = 1'b1;
                wb_sel_o = WB_MEMDAT;
                state_d  = ST_FETCH;
            end

            ST_BR: begin
                alu_opcode_o = OPC_BRANCH;
                alu_funct3_o = funct3_s;
                alu_a_sel_o  = A_RS1;
                alu_b_sel_o  = B_RS2;
                pc_sel_o     = 1'b1;
                // An unsupported funct3 must not redirect the PC
                if (br_valid_s) begin
                    pc_we_o = br_taken_s;
                    state_d = ST_FETCH;
                end else begin
                    pc_we_o = 1'b0;
                    state_d = ST_TRAP;
                end
            end

            ST_JMP: begin
                rf_we_o  = 1'b1;
                wb_sel_o = WB_PC;
                pc_we_o  = 1'b1;
                pc_sel_o = 1'b1;
                state_d  = ST_FETCH;
            end

            ST_TRAP: begin
                illegal_o = 1'b1;
                state_d   = ST_TRAP;
            end

            default: begin
                // Corrupted state encoding: park in TRAP and flag it
                illegal_o = 1'b1;
                state_d   = ST_TRAP;
            end
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        retire_s;

    // An instruction retires when a completing state hands back to FETCH
    assign retire_s = (state_d == ST_FETCH) &&
                      ((state_q == ST_WB) || (state_q == ST_WB_MEM) ||
                       (state_q == ST_MEM_WR) || (state_q == ST_BR) ||
                       (state_q == ST_JMP));

    // Counter increment, wrapping naturally at 2^32
    always_comb begin
        if (retire_s) begin
            instret_d = instret_q + 32'd1;
        end else begin
            instret_d = instret_q;
        end
    end

    // Retired-instruction counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret_o = instret_q;
`else
    // Retired-instruction counter not built
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    // Encodings taken independently of the design package
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0080A283;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BLT  = 32'h0020C063;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_BBAD = 32'h0020A063;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       asel;
        logic       irwe;
        logic       pcwe;
        logic       pcsel;
        logic       rfwe;
        logic [1:0] wb;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [1:0] a;
        logic [1:0] b;
        logic       ill;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        mv;
        logic        z;
        logic        l;
        outs_t       exp;
    } vec_t;

    logic        clk;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        mem_valid_i;
    logic        alu_zero_i;
    logic        alu_less_i;
    logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_sel_o, rf_we_o;
    logic [1:0]  wb_sel_o;
    logic [6:0]  alu_opcode_o;
    logic [2:0]  alu_funct3_o;
    logic [6:0]  alu_funct7_o;
    logic [1:0]  alu_a_sel_o;
    logic [1:0]  alu_b_sel_o;
    logic        illegal_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];
    outs_t act;

    multicycle_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .instr_i        (instr_i),
        .mem_valid_i    (mem_valid_i),
        .alu_zero_i     (alu_zero_i),
        .alu_less_i     (alu_less_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_sel_o (mem_addr_sel_o),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .rf_we_o        (rf_we_o),
        .wb_sel_o       (wb_sel_o),
        .alu_opcode_o   (alu_opcode_o),
        .alu_funct3_o   (alu_funct3_o),
        .alu_funct7_o   (alu_funct7_o),
        .alu_a_sel_o    (alu_a_sel_o),
        .alu_b_sel_o    (alu_b_sel_o),
        .illegal_o      (illegal_o)
`ifdef CTRL_PERF_CNT_EN
        ,
        .instret_o      (instret_o)
`endif
    );

    assign act = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_sel_o, rf_we_o,
                  wb_sel_o, alu_opcode_o, alu_funct3_o, alu_funct7_o, alu_a_sel_o, alu_b_sel_o,
                  illegal_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected outputs of each controller phase, written from the phase description
    function automatic outs_t o_mk(input logic req, input logic we, input logic asel,
                                   input logic irwe, input logic pcwe, input logic pcsel,
                                   input logic rfwe, input logic [1:0] wb, input logic [6:0] op,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [1:0] a, input logic [1:0] b, input logic ill);
        outs_t o;
        o = {req, we, asel, irwe, pcwe, pcsel, rfwe, wb, op, f3, f7, a, b, ill};
        return o;
    endfunction

    function automatic outs_t o_zero();
        return o_mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 7'd0, 3'd0, 7'd0, 2'd0, 2'd0, 0);
    endfunction
    function automatic outs_t o_req();
        return o_mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 7'd0, 3'd0, 7'd0, 2'd0, 2'd0, 0);
    endfunction
    function automatic outs_t o_fetch();
        return o_mk(1, 0, 0, 1, 1, 0, 0, 2'd0, OP_AUIPC, 3'd0, 7'd0, 2'd0, 2'd2, 0);
    endfunction
    function automatic outs_t o_dec();
        return o_mk(0, 0, 0, 0, 0, 0, 0, 2'd0, OP_AUIPC, 3'd0, 7'd0, 2'd1, 2'd1, 0);
    endfunction
    function automatic outs_t o_exec(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [1:0] a, input logic [1:0] b);
        return o_mk(0, 0, 0, 0, 0, 0, 0, 2'd0, op, f3, f7, a, b, 0);
    endfunction
    function automatic outs_t o_rd();
        return o_mk(1, 0, 1, 0, 0, 0, 0, 2'd0, 7'd0, 3'd0, 7'd0, 2'd0, 2'd0, 0);
    endfunction
    function automatic outs_t o_wr();
        return o_mk(1, 1, 1, 0, 0, 0, 0, 2'd0, 7'd0, 3'd0, 7'd0, 2'd0, 2'd0, 0);
    endfunction
    function automatic outs_t o_wb(input logic [1:0] wb);
        return o_mk(0, 0, 0, 0, 0, 0, 1, wb, 7'd0, 3'd0, 7'd0, 2'd0, 2'd0, 0);
    endfunction
    function automatic outs_t o_br(input logic [2:0] f3, input logic taken);
        return o_mk(0, 0, 0, 0, taken, 1, 0, 2'd0, OP_BRANCH, f3, 7'd0, 2'd2, 2'd0, 0);
    endfunction
    function automatic outs_t o_jmp();
        return o_mk(0, 0, 0, 0, 1, 1, 1, 2'd2, 7'd0, 3'd0, 7'd0, 2'd0, 2'd0, 0);
    endfunction
    function automatic outs_t o_trap();
        return o_mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 7'd0, 3'd0, 7'd0, 2'd0, 2'd0, 1);
    endfunction

    task automatic add(input logic rst, input logic [31:0] ins, input logic mv,
                       input logic z, input logic l, input outs_t exp);
        vec_t v;
        v.rst = rst; v.instr = ins; v.mv = mv; v.z = z; v.l = l; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // Reference model: per-instruction latency and pulse counts from the spec rules,
    // with a bench-side memory that answers after d0 (fetch) / d1 (data) wait cycles.
    task automatic run_instr(input logic [31:0] ins, input logic z, input logic l,
                             input int d0, input int d1);
        logic [6:0] op;
        logic [2:0] f3;
        logic       taken;
        logic [1:0] exp_wb;
        int         lat, exp_rf, exp_pc, exp_mw;
        int         n_ir, n_rf, n_pc, n_mw, n_ill, wb_bad;
        int         cnt_f, cnt_d;
        logic       mv;
`ifdef CTRL_PERF_CNT_EN
        logic [31:0] ret_before;
`endif
        op = ins[6:0];
        f3 = ins[14:12];
        case (f3)
            3'b000:  taken = z;
            3'b001:  taken = !z;
            3'b100:  taken = l;
            default: taken = !l;
        endcase
        if (op == OP_BRANCH || op == OP_JAL) lat = 3;
        else if (op == OP_LOAD)              lat = 5;
        else                                 lat = 4;
        lat += d0;
        if (op == OP_LOAD || op == OP_STORE) lat += d1;
        exp_rf = (op == OP_BRANCH || op == OP_STORE) ? 0 : 1;
        exp_pc = 1 + (((op == OP_JAL) || (op == OP_BRANCH && taken)) ? 1 : 0);
        exp_mw = (op == OP_STORE) ? d1 + 1 : 0;
        exp_wb = (op == OP_LOAD) ? 2'b01 : ((op == OP_JAL) ? 2'b10 : 2'b00);

        n_ir = 0; n_rf = 0; n_pc = 0; n_mw = 0; n_ill = 0; wb_bad = 0;
        cnt_f = d0; cnt_d = d1;
`ifdef CTRL_PERF_CNT_EN
        ret_before = instret_o;
`endif
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            if (c == 0) begin
                instr_i    = ins;
                alu_zero_i = z;
                alu_less_i = l;
                check("start_in_fetch", {62'd0, mem_req_o, mem_addr_sel_o}, 64'd2);
            end
            if (mem_req_o) begin
                mv = mem_addr_sel_o ? (cnt_d == 0) : (cnt_f == 0);
            end else begin
                mv = 1'($urandom_range(0, 1));
            end
            mem_valid_i = mv;
            #1;
            n_ir  += int'(ir_we_o);
            n_rf  += int'(rf_we_o);
            n_pc  += int'(pc_we_o);
            n_mw  += int'(mem_we_o);
            n_ill += int'(illegal_o);
            if (rf_we_o && wb_sel_o != exp_wb) wb_bad++;
            if (mem_req_o && !mv) begin
                if (mem_addr_sel_o) cnt_d--;
                else                cnt_f--;
            end
        end
        @(posedge clk);
        #1;
        check("ir_we_count", 64'(n_ir), 64'd1);
        check("rf_we_count", 64'(n_rf), 64'(exp_rf));
        check("pc_we_count", 64'(n_pc), 64'(exp_pc));
        check("mem_we_cycles", 64'(n_mw), 64'(exp_mw));
        check("wb_sel_bad", 64'(wb_bad), 64'd0);
        check("illegal_seen", 64'(n_ill), 64'd0);
`ifdef CTRL_PERF_CNT_EN
        check("instret_step", 64'(instret_o), 64'(ret_before + 32'd1));
`endif
    endtask

    initial begin
        rst_i = 1'b1; instr_i = 32'd0; mem_valid_i = 1'b0; alu_zero_i = 1'b0; alu_less_i = 1'b0;

        // reset held 3 cycles with memory responding, then release
        for (int i = 0; i < 3; i++) add(1, I_ADD, 1, 0, 0, o_zero());
        add(0, I_ADD, 0, 0, 0, o_zero());
        add(0, I_ADD, 0, 0, 0, o_req());
        // ADD: ir_we cycle 1, rf_we cycle 4
        add(0, I_ADD, 1, 0, 0, o_fetch());
        add(0, I_ADD, 1, 0, 0, o_dec());
        add(0, I_ADD, 0, 0, 0, o_exec(OP_R, 3'd0, 7'd0, 2'd2, 2'd0));
        add(0, I_ADD, 0, 0, 0, o_wb(2'b00));
        // LW with 2 wait cycles in MEM_RD
        add(0, I_LW, 1, 0, 0, o_fetch());
        add(0, I_LW, 0, 0, 0, o_dec());
        add(0, I_LW, 0, 0, 0, o_exec(OP_LOAD, 3'd2, 7'd0, 2'd2, 2'd1));
        add(0, I_LW, 0, 0, 0, o_rd());
        add(0, I_LW, 0, 0, 0, o_rd());
        add(0, I_LW, 1, 0, 0, o_rd());
        add(0, I_LW, 0, 0, 0, o_wb(2'b01));
        // BEQ taken / not taken, BLT taken
        add(0, I_BEQ, 1, 1, 0, o_fetch());
        add(0, I_BEQ, 0, 1, 0, o_dec());
        add(0, I_BEQ, 0, 1, 0, o_br(3'd0, 1));
        add(0, I_BEQ, 1, 0, 0, o_fetch());
        add(0, I_BEQ, 0, 0, 0, o_dec());
        add(0, I_BEQ, 0, 0, 0, o_br(3'd0, 0));
        add(0, I_BLT, 1, 0, 1, o_fetch());
        add(0, I_BLT, 0, 0, 1, o_dec());
        add(0, I_BLT, 0, 0, 1, o_br(3'd4, 1));
        // SW with one wait cycle
        add(0, I_SW, 1, 0, 0, o_fetch());
        add(0, I_SW, 0, 0, 0, o_dec());
        add(0, I_SW, 0, 0, 0, o_exec(OP_STORE, 3'd2, 7'd0, 2'd2, 2'd1));
        add(0, I_SW, 0, 0, 0, o_wr());
        add(0, I_SW, 1, 0, 0, o_wr());
        // JAL
        add(0, I_JAL, 1, 0, 0, o_fetch());
        add(0, I_JAL, 1, 0, 0, o_dec());
        add(0, I_JAL, 1, 0, 0, o_jmp());
        // LUI: operand A is ZERO, raw funct fields go to the ALU
        add(0, I_LUI, 1, 0, 0, o_fetch());
        add(0, I_LUI, 0, 0, 0, o_dec());
        add(0, I_LUI, 0, 0, 0, o_exec(OP_LUI, 3'd5, 7'd9, 2'd3, 2'd1));
        add(0, I_LUI, 0, 0, 0, o_wb(2'b00));
        // ADD aborted by reset in EXEC
        add(0, I_ADD, 0, 0, 0, o_req());
        add(0, I_ADD, 1, 0, 0, o_fetch());
        add(0, I_ADD, 0, 0, 0, o_dec());
        add(1, I_ADD, 0, 0, 0, o_zero());
        add(0, I_ADD, 0, 0, 0, o_zero());
        add(0, I_ADD, 0, 0, 0, o_req());

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_i = vecs[i].rst; instr_i = vecs[i].instr; mem_valid_i = vecs[i].mv;
            alu_zero_i = vecs[i].z; alu_less_i = vecs[i].l;
            #1;
            check($sformatf("vec%0d", i), 64'(act), 64'(vecs[i].exp));
        end

        // Illegal opcode -> TRAP held 10 cycles, then async reset clears it
        @(negedge clk); instr_i = 32'd0; mem_valid_i = 1'b1; #1;
        check("trap_fetch", 64'(act), 64'(o_fetch()));
        @(negedge clk); #1;
        check("trap_decode", 64'(act), 64'(o_dec()));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); mem_valid_i = 1'($urandom_range(0, 1)); #1;
            check($sformatf("trap_hold%0d", k), 64'(act), 64'(o_trap()));
        end
        @(negedge clk); rst_i = 1'b1; #1;
        check("trap_async_rst", 64'(act), 64'(o_zero()));
        @(negedge clk); rst_i = 1'b0;

        // Unsupported branch funct3 -> no PC write, then TRAP
        @(negedge clk); instr_i = I_BBAD; mem_valid_i = 1'b1; alu_zero_i = 1'b1; #1;
        check("bbad_fetch", 64'(act), 64'(o_fetch()));
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("bbad_br", 64'(act), 64'(o_br(3'd2, 0)));
        @(negedge clk); #1;
        check("bbad_trap", 64'(act), 64'(o_trap()));
        pulse_reset();

        // Randomized instruction stream against the latency/pulse model
        for (int n = 0; n < 200; n++) begin
            logic [31:0] r;
            logic [6:0]  ops[8];
            logic [2:0]  bf3[4];
            ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL};
            bf3 = '{3'd0, 3'd1, 3'd4, 3'd5};
            r = $urandom();
            r[6:0] = ops[$urandom_range(0, 7)];
            if (r[6:0] == OP_BRANCH) r[14:12] = bf3[$urandom_range(0, 3)];
            run_instr(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

`ifdef CTRL_PERF_CNT_EN
        pulse_reset();
        run_instr(I_ADD, 1'b0, 1'b0, 0, 0);
        run_instr(I_LW, 1'b0, 1'b0, 0, 0);
        run_instr(I_BEQ, 1'b1, 1'b0, 0, 0);
        check("instret_three", 64'(instret_o), 64'd3);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        run_instr(I_ADD, 1'b0, 1'b0, 0, 0);
        check("instret_wrap", 64'(instret_o), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
